// File: rtl/imm_pack_pkg.sv
// Shared types and field constants for the immediate packer.
package imm_pack_pkg;

  // Immediate format select, same encoding as the immediate extender.
  typedef enum logic [2:0] {
    SrcI = 3'b000,
    SrcS = 3'b001,
    SrcB = 3'b010,
    SrcJ = 3'b011,
    SrcU = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    ErrOk       = 2'b00,
    ErrRange    = 2'b01,
    ErrMisalign = 2'b10,
    ErrIllegal  = 2'b11
  } err_e;

  // Instruction bits occupied by the immediate in each format.
  localparam logic [31:0] MaskI = 32'hFFF0_0000;
  localparam logic [31:0] MaskS = 32'hFE00_0F80;
  localparam logic [31:0] MaskB = 32'hFE00_0F80;
  localparam logic [31:0] MaskJ = 32'hFFFF_F000;
  localparam logic [31:0] MaskU = 32'hFFFF_F000;

  function automatic logic [31:0] fmt_mask(logic [2:0] src);
    logic [31:0] m;
    case (src)
      SrcI:    m = MaskI;
      SrcS:    m = MaskS;
      SrcB:    m = MaskB;
      SrcJ:    m = MaskJ;
      SrcU:    m = MaskU;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/imm_pack_if.sv
// Request/result handshake bundle for the immediate packer.
interface imm_pack_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  imm_src_i;
  logic [31:0] instr_i;
  logic [31:0] imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] instr_o;
  logic [1:0]  err_o;

  modport slave (
    input  in_valid_i, imm_src_i, instr_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, err_o
  );

  modport master (
    output in_valid_i, imm_src_i, instr_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, err_o
  );
endinterface

// File: rtl/imm_range_chk.sv
// Combinational legality check of an immediate against its target format.
// Priority: illegal format > misaligned > out of range.
module imm_range_chk
  import imm_pack_pkg::*;
(
  input  logic [2:0]  imm_src_i,
  input  logic [31:0] imm_i,
  output err_e        err_o
);

  logic fits12, fits13, fits21;

  // Upper bits all equal means the value sign-extends from the field width.
  assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  // Per-format error decode.
  always_comb begin
    err_o = ErrOk;
    case (imm_src_i)
      SrcI, SrcS: if (!fits12) err_o = ErrRange;
      SrcB: begin
        if (imm_i[0])     err_o = ErrMisalign;
        else if (!fits13) err_o = ErrRange;
      end
      SrcJ: begin
        if (imm_i[0])     err_o = ErrMisalign;
        else if (!fits21) err_o = ErrRange;
      end
      SrcU:    if (|imm_i[11:0]) err_o = ErrRange;
      default: err_o = ErrIllegal;
    endcase
  end

endmodule

// File: rtl/imm_pack.sv
// Two-stage immediate packer: stage 1 checks range/alignment, stage 2 scatters
// the immediate into the instruction fields. Also counts errored results.
module imm_pack
  import imm_pack_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  imm_pack_if.slave        bus,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] err_cnt_o
);

  logic             adv1, adv2, xfer;
  logic             s1_valid_q;
  logic [2:0]       s1_src_q;
  logic [31:0]      s1_instr_q, s1_imm_q;
  err_e             s1_err_q, chk_err;
  logic             s2_valid_q;
  logic [31:0]      s2_instr_q;
  err_e             s2_err_q;
  logic [31:0]      field, packed_instr;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  imm_range_chk u_chk (
    .imm_src_i (bus.imm_src_i),
    .imm_i     (bus.imm_i),
    .err_o     (chk_err)
  );

  assign adv2 = !s2_valid_q || bus.out_ready_i;
  assign adv1 = !s1_valid_q || adv2;
  assign xfer = s2_valid_q && bus.out_ready_i;

  assign bus.in_ready_o  = adv1;
  assign bus.out_valid_o = s2_valid_q;
  assign bus.instr_o     = s2_instr_q;
  assign bus.err_o       = s2_err_q;
  assign err_cnt_o       = cnt_q;

  // Stage 1 register: capture request and its check result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_src_q   <= '0;
      s1_instr_q <= '0;
      s1_imm_q   <= '0;
      s1_err_q   <= ErrOk;
    end else if (adv1) begin
      s1_valid_q <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_src_q   <= bus.imm_src_i;
        s1_instr_q <= bus.instr_i;
        s1_imm_q   <= bus.imm_i;
        s1_err_q   <= chk_err;
      end
    end
  end

  // Scatter the immediate into its format's fields; errored requests pass through.
  always_comb begin
    field = '0;
    case (s1_src_q)
      SrcI: field[31:20] = s1_imm_q[11:0];
      SrcS: begin
        field[31:25] = s1_imm_q[11:5];
        field[11:7]  = s1_imm_q[4:0];
      end
      SrcB: begin
        field[31]    = s1_imm_q[12];
        field[30:25] = s1_imm_q[10:5];
        field[11:8]  = s1_imm_q[4:1];
        field[7]     = s1_imm_q[11];
      end
      SrcJ: begin
        field[31]    = s1_imm_q[20];
        field[30:21] = s1_imm_q[10:1];
        field[20]    = s1_imm_q[11];
        field[19:12] = s1_imm_q[19:12];
      end
      SrcU:    field[31:12] = s1_imm_q[31:12];
      default: field = '0;
    endcase
    if (s1_err_q == ErrOk) begin
      packed_instr = (s1_instr_q & ~fmt_mask(s1_src_q)) | field;
    end else begin
      packed_instr = s1_instr_q;
    end
  end

  // Stage 2 register: holds the result until the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= ErrOk;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= packed_instr;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  // Saturating error counter; clear has priority over a counted transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr_i) begin
      cnt_d = '0;
    end else if (xfer && (s2_err_q != ErrOk) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule
